// File: rtl/conv_mem_pkg.sv
// conv_mem_pkg
//   Shared sizing constants and region map for the convolution buffer.
//   The 128-word memory is split into kernel, input-activation and output
//   regions; region_of() classifies a full 32-bit accelerator address.
package conv_mem_pkg;

  localparam int DEPTH    = 128;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 7;
  localparam int KER_BASE = 0;
  localparam int INP_BASE = 20;
  localparam int OUT_BASE = 108;
  localparam int OUT_LAST = 127;

  typedef enum logic [1:0] {
    KER,
    INP,
    OUT,
    BAD
  } region_e;

  // Anything past the last output word is outside the array entirely.
  function automatic region_e region_of(input logic [31:0] addr);
    if (addr > 32'(OUT_LAST))       return BAD;
    else if (addr >= 32'(OUT_BASE)) return OUT;
    else if (addr >= 32'(INP_BASE)) return INP;
    else                            return KER;
  endfunction

endpackage

// File: rtl/conv_mem_resp_if.sv
// conv_mem_resp_if
//   Bundles the accelerator port, the host port and the error reporting
//   signals of the convolution buffer.
//   slave  : the memory side (conv_mem_resp)
//   master : the requesting side (accelerator + host + error monitor)
interface conv_mem_resp_if;
  import conv_mem_pkg::*;

  logic [31:0]       acc_addr;
  logic              acc_rd_en;
  logic              acc_wr_en;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_rvalid;
  logic              acc_busy;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              err_clr;
  logic              acc_err;
  logic [7:0]        err_cnt;

  modport slave (
    input  acc_addr, acc_rd_en, acc_wr_en, acc_wdata, acc_busy,
    input  host_req, host_we, host_addr, host_wdata,
    input  err_clr,
    output acc_rdata, acc_rvalid,
    output host_gnt, host_rdata, host_rvalid,
    output acc_err, err_cnt
  );

  modport master (
    output acc_addr, acc_rd_en, acc_wr_en, acc_wdata, acc_busy,
    output host_req, host_we, host_addr, host_wdata,
    output err_clr,
    input  acc_rdata, acc_rvalid,
    input  host_gnt, host_rdata, host_rvalid,
    input  acc_err, err_cnt
  );

endinterface

// File: rtl/sp_ram_128x32.sv
// sp_ram_128x32
//   Single-port 128 x 32 storage with a registered read. Contents are not
//   reset. rdata only changes on a read, so it keeps the last word read
//   across write and idle cycles.
//   clk   : clock
//   en    : port enable
//   we    : write (1) / read (0) when enabled
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read
module sp_ram_128x32
  import conv_mem_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/conv_mem_resp.sv
// conv_mem_resp
//   Convolution buffer front end: arbitrates one single-port RAM between the
//   accelerator (absolute priority) and the host, enforces the accelerator
//   region rules and keeps a sticky error flag plus a saturating count.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : accelerator/host/error signals (slave side)
//     acc_*  : accelerator read/write port, reads answered one cycle later
//     host_* : host port, host_gnt is combinational
//     err_*  : err_clr in, acc_err / err_cnt out
module conv_mem_resp
  import conv_mem_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  conv_mem_resp_if.slave bus
);

  region_e           acc_region;
  logic              acc_wr_legal;
  logic              acc_rd_legal;
  logic              acc_wr_ok;
  logic              acc_rd_ok;
  logic              acc_rd_bad;
  logic              viol;
  logic              host_gnt_c;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              acc_rv_q;
  logic              acc_zero_q;
  logic              host_rv_q;
  logic [DATA_W-1:0] acc_hold_q;
  logic [DATA_W-1:0] host_hold_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;
  logic [DATA_W-1:0] acc_rdata_c;

  always_comb begin
    acc_region   = region_of(bus.acc_addr);
    acc_wr_legal = (acc_region == OUT);
    acc_rd_legal = (acc_region != BAD);

    // A combined read+write strobe performs only the write.
    acc_wr_ok  = !rst && bus.acc_wr_en && acc_wr_legal;
    acc_rd_ok  = !rst && bus.acc_rd_en && !bus.acc_wr_en && acc_rd_legal;
    acc_rd_bad = !rst && bus.acc_rd_en && !bus.acc_wr_en && !acc_rd_legal;

    viol = !rst && ((bus.acc_wr_en && !acc_wr_legal) ||
                    acc_rd_bad ||
                    (bus.acc_rd_en && bus.acc_wr_en));

    host_gnt_c = !rst && bus.host_req && !bus.acc_busy &&
                 !bus.acc_rd_en && !bus.acc_wr_en;

    ram_en    = acc_wr_ok || acc_rd_ok || host_gnt_c;
    ram_we    = acc_wr_ok || (host_gnt_c && bus.host_we);
    ram_addr  = host_gnt_c ? bus.host_addr  : bus.acc_addr[ADDR_W-1:0];
    ram_wdata = host_gnt_c ? bus.host_wdata : bus.acc_wdata;
  end

  sp_ram_128x32 u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Out-of-range reads never touch the RAM and answer with zero.
  assign acc_rdata_c = acc_zero_q ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_rv_q    <= 1'b0;
      acc_zero_q  <= 1'b0;
      host_rv_q   <= 1'b0;
      acc_hold_q  <= '0;
      host_hold_q <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      acc_rv_q   <= acc_rd_ok || acc_rd_bad;
      acc_zero_q <= acc_rd_bad;
      host_rv_q  <= host_gnt_c && !bus.host_we;

      // The RAM read register is shared, so each port keeps its own copy
      // of the last word it was given.
      if (acc_rv_q)  acc_hold_q  <= acc_rdata_c;
      if (host_rv_q) host_hold_q <= ram_rdata;

      // A violation in the same cycle as err_clr restarts the count at one.
      if (viol) begin
        err_q <= 1'b1;
        if (bus.err_clr)              err_cnt_q <= 8'd1;
        else if (err_cnt_q != 8'hFF)  err_cnt_q <= err_cnt_q + 8'd1;
      end else if (bus.err_clr) begin
        err_q     <= 1'b0;
        err_cnt_q <= 8'd0;
      end
    end
  end

  // Reset masks the read responses immediately so a read already in flight
  // when rst rises never shows its valid pulse.
  assign bus.acc_rvalid  = acc_rv_q && !rst;
  assign bus.acc_rdata   = rst ? '0 : (acc_rv_q ? acc_rdata_c : acc_hold_q);
  assign bus.host_rvalid = host_rv_q && !rst;
  assign bus.host_rdata  = rst ? '0 : (host_rv_q ? ram_rdata : host_hold_q);
  assign bus.host_gnt    = host_gnt_c;
  assign bus.acc_err     = err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_conv_mem_resp.sv
// tb_conv_mem_resp
//   Scoreboard bench for conv_mem_resp: reads push the expected word and
//   the cycle it must appear in; a negedge monitor pops and compares.
module tb_conv_mem_resp;
  import conv_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mem_resp_if bus();

  conv_mem_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          stamp;
    logic [31:0] data;
  } exp_t;

  exp_t        acc_q[$];
  exp_t        host_q[$];
  exp_t        ea;
  exp_t        eh;
  logic [31:0] model [128];
  int          cyc      = 0;
  int          n_vec    = 0;
  int          n_miss   = 0;
  int          exp_cnt  = 0;
  logic        exp_err  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.acc_addr   = '0;
    bus.acc_rd_en  = 1'b0;
    bus.acc_wr_en  = 1'b0;
    bus.acc_wdata  = '0;
    bus.acc_busy   = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.err_clr    = 1'b0;
  endtask

  task automatic note_viol(input logic clr);
    if (clr)                exp_cnt = 1;
    else if (exp_cnt < 255) exp_cnt++;
    exp_err = 1'b1;
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_err"}, 32'(bus.acc_err), 32'(exp_err));
    chk({tag, "_cnt"}, 32'(bus.err_cnt), exp_cnt);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [31:0] d);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    model[a]       = d;
    tick();
    idle();
  endtask

  task automatic host_read(input logic [6:0] a);
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = a;
    host_q.push_back('{cyc + 1, model[a]});
    tick();
    idle();
  endtask

  task automatic acc_read(input logic [31:0] a);
    bus.acc_addr  = a;
    bus.acc_rd_en = 1'b1;
    if (a < 128) acc_q.push_back('{cyc + 1, model[a[6:0]]});
    else begin
      acc_q.push_back('{cyc + 1, 32'h0});
      note_viol(1'b0);
    end
    tick();
    idle();
  endtask

  task automatic acc_write(input logic [31:0] a, input logic [31:0] d);
    bus.acc_addr  = a;
    bus.acc_wr_en = 1'b1;
    bus.acc_wdata = d;
    if (a >= 108 && a <= 127) model[a[6:0]] = d;
    else                      note_viol(1'b0);
    tick();
    idle();
  endtask

  // Each response must arrive exactly in the cycle its request stamped.
  always @(negedge clk) begin
    if (bus.acc_rvalid) begin
      if (acc_q.size() == 0) chk("acc_rvalid_unexp", 32'd1, 32'd0);
      else begin
        ea = acc_q.pop_front();
        chk("acc_rvalid_cycle", cyc, ea.stamp);
        chk("acc_rdata", bus.acc_rdata, ea.data);
      end
    end else if (acc_q.size() != 0 && acc_q[0].stamp <= cyc) begin
      chk("acc_rvalid_miss", 32'd0, 32'd1);
      void'(acc_q.pop_front());
    end
    if (bus.host_rvalid) begin
      if (host_q.size() == 0) chk("host_rvalid_unexp", 32'd1, 32'd0);
      else begin
        eh = host_q.pop_front();
        chk("host_rvalid_cycle", cyc, eh.stamp);
        chk("host_rdata", bus.host_rdata, eh.data);
      end
    end else if (host_q.size() != 0 && host_q[0].stamp <= cyc) begin
      chk("host_rvalid_miss", 32'd0, 32'd1);
      void'(host_q.pop_front());
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b1;
    bus.host_addr = 7'd3;
    tick();
    tick();
    #1;
    chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rst_acc_rdata", bus.acc_rdata, 32'h0);
    chk("rst_host_rdata", bus.host_rdata, 32'h0);
    chk("rst_acc_rvalid", 32'(bus.acc_rvalid), 32'd0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk_err("rst");
    idle();
    rst = 1'b0;
    tick();

    // Preload, then first accelerator read from the input region.
    for (int i = 0; i < 128; i++) host_write(7'(i), 32'hA5A5_0000 + 32'(i));
    acc_read(32'd20);
    tick();
    chk("acc_hold_20", bus.acc_rdata, 32'hA5A5_0014);

    // Legal output write then read-back, illegal input-region write.
    acc_write(32'd108, 32'h0000_1234);
    acc_read(32'd108);
    acc_write(32'd50, 32'h0000_DEAD);
    chk_err("wr50");
    host_read(7'd50);
    tick();
    chk("acc_hold_1234", bus.acc_rdata, 32'h0000_1234);
    chk("host_hold_50", bus.host_rdata, 32'hA5A5_0032);

    // Host blocked while the accelerator owns memory.
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 7'd7;
    bus.acc_busy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_gnt", 32'(bus.host_gnt), 32'd0);
      tick();
    end
    bus.acc_busy = 1'b0;
    host_q.push_back('{cyc + 1, model[7]});
    #1;
    chk("unbusy_gnt", 32'(bus.host_gnt), 32'd1);
    tick();
    idle();

    // Accelerator read strobe also takes priority over the host.
    bus.host_req  = 1'b1;
    bus.host_addr = 7'd9;
    bus.acc_addr  = 32'd5;
    bus.acc_rd_en = 1'b1;
    acc_q.push_back('{cyc + 1, model[5]});
    #1;
    chk("rd_prio_gnt", 32'(bus.host_gnt), 32'd0);
    tick();
    idle();

    // Out-of-range reads answer zero and count.
    acc_read(32'd200);
    acc_read(32'h8000_0014);
    chk_err("badrd");

    // Read and write together: write only, no response, counted.
    bus.acc_addr  = 32'd127;
    bus.acc_rd_en = 1'b1;
    bus.acc_wr_en = 1'b1;
    bus.acc_wdata = 32'h0000_0077;
    model[127]    = 32'h0000_0077;
    note_viol(1'b0);
    tick();
    idle();
    acc_read(32'd127);
    chk_err("both");

    // Saturation, clear, clear racing a violation.
    for (int i = 0; i < 300; i++) acc_write(32'(i % 108), $urandom);
    chk_err("sat");
    host_read(7'd0);
    host_read(7'd19);
    host_read(7'd107);
    acc_read(32'd21);
    bus.err_clr = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
    tick();
    idle();
    chk_err("clr");
    bus.err_clr   = 1'b1;
    bus.acc_addr  = 32'd10;
    bus.acc_wr_en = 1'b1;
    bus.acc_wdata = 32'hCAFE_0000;
    note_viol(1'b1);
    tick();
    idle();
    chk_err("clr_viol");

    // Reset while a read is in flight; writes during reset are ignored.
    bus.acc_addr  = 32'd20;
    bus.acc_rd_en = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 7'd5;
    bus.host_wdata = 32'hFFFF_FFFF;
    #1;
    chk("inflight_rvalid", 32'(bus.acc_rvalid), 32'd0);
    chk("inflight_rdata", bus.acc_rdata, 32'h0);
    chk("inflight_gnt", 32'(bus.host_gnt), 32'd0);
    tick();
    bus.acc_addr  = 32'd110;
    bus.acc_wr_en = 1'b1;
    bus.acc_wdata = 32'h0BAD_0BAD;
    exp_cnt = 0;
    exp_err = 1'b0;
    #1;
    chk("rst2_acc_rvalid", 32'(bus.acc_rvalid), 32'd0);
    chk("rst2_acc_rdata", bus.acc_rdata, 32'h0);
    chk("rst2_host_rdata", bus.host_rdata, 32'h0);
    chk("rst2_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst2_gnt", 32'(bus.host_gnt), 32'd0);
    chk_err("rst2");
    tick();
    idle();
    rst = 1'b0;
    tick();
    host_read(7'd5);
    host_read(7'd20);
    acc_read(32'd110);

    tick();
    tick();
    tick();
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    chk("host_q_drained", 32'(host_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/conv_mem_resp.md
CONV_MEM_RESP -- requirements
Module: conv_mem_resp

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 acc_addr  in  32  accelerator word address, from the pointer mux.
REQ-004 acc_rd_en  in  1  accelerator read strobe, one word per cycle.
REQ-005 acc_wr_en  in  1  accelerator write strobe, one word per cycle.
REQ-006 acc_wdata  in  32  accelerator write data.
REQ-007 acc_rdata  out  32  accelerator read data, registered.
REQ-008 acc_rvalid  out  1  acc_rdata valid pulse.
REQ-009 acc_busy  in  1  accelerator owns memory; host is blocked.
REQ-010 host_req  in  1  host access request.
REQ-011 host_we  in  1  host write (1) / read (0).
REQ-012 host_addr  in  7  host word address, 0..127.
REQ-013 host_wdata  in  32  host write data.
REQ-014 host_gnt  out  1  host access accepted this cycle (combinational).
REQ-015 host_rdata  out  32  host read data, registered.
REQ-016 host_rvalid  out  1  host_rdata valid pulse.
REQ-017 err_clr  in  1  clears acc_err and err_cnt.
REQ-018 acc_err  out  1  sticky access-violation flag.
REQ-019 err_cnt  out  8  saturating violation count.

Function
REQ-020 Storage SHALL be 128 x 32-bit, single port, with regions kernel 0..19, input 20..107, output 108..127.
REQ-021 Accelerator reads SHALL be legal at addresses 0..127.
REQ-022 Accelerator writes SHALL be legal only at addresses 108..127.
REQ-023 acc_rd_en at cycle N with a legal address SHALL produce acc_rdata = mem[addr] and acc_rvalid=1 at cycle N+1, for exactly one cycle.
REQ-024 A read at addr >= 128 SHALL give acc_rdata=0 and acc_rvalid=1 at N+1, and SHALL count as a violation.
REQ-025 A legal acc_wr_en SHALL update memory at the clock edge; a read of the same address next cycle SHALL return the new data.
REQ-026 An illegal write (addr < 108 or >= 128) SHALL leave memory unchanged and SHALL count as a violation.
REQ-027 acc_rd_en and acc_wr_en high together SHALL perform the write only (if legal), SHALL NOT assert acc_rvalid, and SHALL count as a violation.
REQ-028 host_gnt = host_req & !acc_busy & !acc_rd_en & !acc_wr_en; the accelerator has absolute priority.
REQ-029 A granted host write SHALL update mem[host_addr] at the edge.
REQ-030 A granted host read SHALL give host_rdata/host_rvalid at N+1; an ungranted request SHALL have no effect, and the host holds its request.
REQ-031 Host access SHALL be unrestricted by region.
REQ-032 Each violation cycle SHALL set acc_err and increment err_cnt by one, saturating at 255.
REQ-033 err_clr SHALL zero both acc_err and err_cnt; a violation in the same cycle SHALL win (acc_err=1, err_cnt=1).
REQ-034 acc_rdata and host_rdata SHALL hold their last value when the matching rvalid is low.

Reset
REQ-035 rst SHALL set acc_rdata=0, host_rdata=0, acc_rvalid=0, host_rvalid=0, acc_err=0 and err_cnt=0.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 rst asserted while a read is in flight SHALL suppress the N+1 rvalid.
REQ-038 During rst, writes SHALL be ignored and host_gnt SHALL be 0.

Structure
REQ-039 Package conv_mem_pkg SHALL hold DEPTH=128, DATA_W=32, KER_BASE=0, INP_BASE=20, OUT_BASE=108, OUT_LAST=127 and the region enum (KER, INP, OUT, BAD).
REQ-040 The storage array SHALL be sub-module sp_ram_128x32 (single port, 1-cycle registered read); arbitration, checking and error logic SHALL stay in conv_mem_resp.

Verification
REQ-041 Host writes 0xA5A5_0000+i to addresses 0..127, then the accelerator reads address 20 -> acc_rdata=0xA5A5_0014, acc_rvalid=1 one cycle later.
REQ-042 Accelerator writes 0x1234 at 108, then reads 108 -> 0x1234; a write of 0xDEAD at 50 -> mem[50] unchanged, acc_err=1, err_cnt=1.
REQ-043 host_req with acc_busy=1 for 3 cycles -> host_gnt=0 for those cycles; acc_busy drops -> host_gnt=1 and host_rvalid one cycle later.
REQ-044 acc_rd_en and acc_wr_en together at 127 with data 0x77 -> mem[127]=0x77, no acc_rvalid, err_cnt increments.
REQ-045 300 illegal writes -> err_cnt=255; err_clr -> 0; err_clr with a simultaneous violation -> err_cnt=1.
REQ-046 rst asserted the cycle after acc_rd_en -> acc_rvalid stays 0 and all outputs are 0; memory still holds the preloaded data.
